// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver.
// Configurable data width, optional odd/even parity and one or two stop bits.
// The serial line is double-flopped before use, start bits are re-checked at
// mid-bit to reject glitches, and each frame ends with a one-cycle strobe that
// carries the word together with parity, framing and break flags.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 2,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Rx_Active
);

  // Half a bit period: the start bit is re-checked at this count.
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  // Index of the final stop sample: 0 for one stop bit, 1 for two.
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } state_t;

  // XOR of all data bits of a word.
  function automatic logic word_parity(input logic [DATA_BITS-1:0] word);
    return ^word;
  endfunction

  // True when the received parity bit does not match the configured sense.
  // Even parity needs data^parity == 0, odd parity needs it to be 1.
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] word,
                                           input logic par_bit);
    logic sum;
    sum = word_parity(word) ^ par_bit;
    return PAR_ODD ? ~sum : sum;
  endfunction

  logic                 sync1_r;
  logic                 sync2_r;
  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 stop_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bit_r;
  logic                 par_err_pend_r;
  logic                 frame_err_pend_r;

  logic                 rx_dv_r;
  logic [DATA_BITS-1:0] rx_byte_r;
  logic                 parity_err_r;
  logic                 frame_err_r;
  logic                 break_r;
  logic                 rx_active_r;

  logic                 break_hit_s;

  // Break: every data bit low, parity low when present, and the stop sample
  // now being taken is low as well.
  assign break_hit_s = (shift_r == '0) && (!PAR_EN || !par_bit_r) && !sync2_r;

  assign o_Rx_DV      = rx_dv_r;
  assign o_Rx_Byte    = rx_byte_r;
  assign o_Parity_Err = parity_err_r;
  assign o_Frame_Err  = frame_err_r;
  assign o_Break      = break_r;
  assign o_Rx_Active  = rx_active_r;

  // Two-flop synchroniser for the asynchronous line; idles high out of reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= i_Rx_Serial;
      sync2_r <= sync1_r;
    end
  end

  // Frame FSM: bit timing, sampling, error accumulation and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r          <= ST_IDLE;
      cnt_r            <= '0;
      idx_r            <= '0;
      stop_idx_r       <= 1'b0;
      shift_r          <= '0;
      par_bit_r        <= 1'b0;
      par_err_pend_r   <= 1'b0;
      frame_err_pend_r <= 1'b0;
      rx_dv_r          <= 1'b0;
      rx_byte_r        <= '0;
      parity_err_r     <= 1'b0;
      frame_err_r      <= 1'b0;
      break_r          <= 1'b0;
      rx_active_r      <= 1'b0;
    end else begin
      // The strobe is a single cycle; only the frame-end branches raise it.
      rx_dv_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (!sync2_r) begin
            state_r <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r <= '0;
            if (!sync2_r) begin
              // Still low at mid-bit: a genuine start bit.
              state_r          <= ST_DATA;
              rx_active_r      <= 1'b1;
              idx_r            <= '0;
              stop_idx_r       <= 1'b0;
              par_bit_r        <= 1'b0;
              par_err_pend_r   <= 1'b0;
              frame_err_pend_r <= 1'b0;
            end else begin
              // Glitch: drop it silently, outputs untouched.
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            // LSB arrives first, so shift in from the top.
            shift_r <= {sync2_r, shift_r[DATA_BITS-1:1]};
            if (idx_r == IDX_LAST) begin
              idx_r      <= '0;
              stop_idx_r <= 1'b0;
              state_r    <= PAR_EN ? ST_PARITY : ST_STOP;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        ST_PARITY: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r          <= '0;
            par_bit_r      <= sync2_r;
            par_err_pend_r <= parity_mismatch(shift_r, sync2_r);
            stop_idx_r     <= 1'b0;
            state_r        <= ST_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            if (!stop_idx_r && break_hit_s) begin
              // Break: report immediately and skip any second stop bit.
              rx_dv_r      <= 1'b1;
              rx_byte_r    <= '0;
              parity_err_r <= par_err_pend_r;
              frame_err_r  <= 1'b1;
              break_r      <= 1'b1;
              rx_active_r  <= 1'b0;
              state_r      <= ST_BREAK_WAIT;
            end else if (stop_idx_r == STOP_LAST) begin
              rx_dv_r      <= 1'b1;
              rx_byte_r    <= shift_r;
              parity_err_r <= par_err_pend_r;
              frame_err_r  <= frame_err_pend_r | ~sync2_r;
              break_r      <= 1'b0;
              rx_active_r  <= 1'b0;
              state_r      <= ST_IDLE;
            end else begin
              frame_err_pend_r <= frame_err_pend_r | ~sync2_r;
              stop_idx_r       <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        ST_BREAK_WAIT: begin
          cnt_r <= '0;
          // Hold off until the line is released so the break is reported once.
          if (sync2_r) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_BREAK_WAIT;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= '0;
          rx_active_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: self-checking bench for uart_rx_cfg.
// Three receivers share clock and reset: 8N1, 8E1 and 7O2, all at four clocks
// per bit. Expected words are queued when a frame is driven; a monitor records
// every strobe and each test pops and compares both queues.
module tb_uart_rx_cfg;

  localparam int CPB   = 4;
  localparam int H     = CPB / 2;
  localparam int LIMIT = 600;

  typedef struct {
    int         dut;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
    logic       act;
    int         cyc;
  } rec_t;

  typedef struct {
    int dut;
    int cyc;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [2:0] rx;
  logic [2:0] dv, pe, fe, brk, act;
  logic [2:0] act_d;
  logic [7:0] byte_a, byte_b;
  logic [6:0] byte_c;
  logic [8:0] byte_o [3];

  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;
  rec_t sb[$];
  rec_t obs[$];
  ev_t  rise_q[$];

  assign byte_o[0] = {1'b0, byte_a};
  assign byte_o[1] = {1'b0, byte_b};
  assign byte_o[2] = {2'b00, byte_c};

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]),
    .o_Rx_Byte(byte_a), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]),
    .o_Break(brk[0]), .o_Rx_Active(act[0])
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_8e1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]),
    .o_Rx_Byte(byte_b), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]),
    .o_Break(brk[1]), .o_Rx_Active(act[1])
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_7o2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]),
    .o_Rx_Byte(byte_c), .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]),
    .o_Break(brk[2]), .o_Rx_Active(act[2])
  );

  initial clk = 1'b0;
  // 10-unit clock period.
  always #5 clk = ~clk;

  // Rising-edge counter: at the falling edge after edge k it reads k.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every strobe and every rising edge of Rx_Active.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i] === 1'b1)
        obs.push_back('{dut: i, data: byte_o[i], pe: pe[i], fe: fe[i], brk: brk[i], act: act[i], cyc: cyc});
      if (act[i] === 1'b1 && act_d[i] !== 1'b1)
        rise_q.push_back('{dut: i, cyc: cyc});
    end
    act_d <= act;
  end

  // Global time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int d, input logic [8:0] data, input logic p, input logic f, input logic b);
    sb.push_back('{dut: d, data: data, pe: p, fe: f, brk: b, act: 1'b0, cyc: 0});
  endtask

  // Drive one frame, CPB cycles per bit, changing the line on falling edges.
  // e0 is the rising edge that first captures the start bit.
  task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                            input int par_mode, input logic bad_par,
                            input logic [1:0] stops, input int nstop, output int e0);
    logic [15:0] fb;
    int          n;
    logic        p;
    fb = '1;
    n  = 0;
    fb[n] = 1'b0; n++;
    for (int i = 0; i < nbits; i++) begin fb[n] = data[i]; n++; end
    if (par_mode != 0) begin
      p = 1'b0;
      for (int i = 0; i < nbits; i++) p = p ^ data[i];
      if (par_mode == 1) p = ~p;
      fb[n] = p ^ bad_par; n++;
    end
    for (int i = 0; i < nstop; i++) begin fb[n] = stops[i]; n++; end
    e0 = 0;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        rx[d] = fb[b];
        if (b == 0 && c == 0) e0 = cyc + 1;
      end
    end
  endtask

  task automatic idle_line(input int n);
    @(negedge clk);
    rx = 3'b111;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 3'b111;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dv[i], pe[i], fe[i], brk[i], act[i]} !== 5'b00000) begin
        fails++;
        $display("FAIL reset_flags dut%0d: got dv/pe/fe/brk/act=%b, expected 00000", i, {dv[i], pe[i], fe[i], brk[i], act[i]});
      end
      checks++;
      if (byte_o[i] !== 9'h000) begin
        fails++;
        $display("FAIL reset_byte dut%0d: got %h, expected 000", i, byte_o[i]);
      end
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    rec_t o, e;
    int   e0a, e0b, k;
    rise_q.delete();
    push_exp(0, 9'h0AA, 1'b0, 1'b0, 1'b0);
    push_exp(0, 9'h055, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h0AA, 8, 0, 1'b0, 2'b11, 1, e0a);
    send_frame(0, 9'h055, 8, 0, 1'b0, 2'b11, 1, e0b);
    idle_line(1);
    for (int t = 0; t < LIMIT && obs.size() < sb.size(); t++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (obs.size() != sb.size()) begin
      fails++;
      $display("FAIL b2b_count: got %0d strobes, expected %0d", obs.size(), sb.size());
    end
    k = 0;
    while (obs.size() > 0 && sb.size() > 0) begin
      o = obs.pop_front(); e = sb.pop_front(); checks++;
      if ({o.dut, o.data, o.pe, o.fe, o.brk, o.act} !== {e.dut, e.data, e.pe, e.fe, e.brk, e.act}) begin
        fails++;
        $display("FAIL b2b_word%0d: got dut=%0d data=%h pe=%b fe=%b brk=%b act=%b, expected dut=%0d data=%h pe=0 fe=0 brk=0 act=0",
                 k, o.dut, o.data, o.pe, o.fe, o.brk, o.act, e.dut, e.data);
      end
      if (k == 0) begin
        // Strobe is visible in the cycle after edge E0+2+H+CPB*N+1, N=9 for 8N1.
        checks++;
        if (o.cyc != e0a + 2 + H + CPB * 9 + 1) begin
          fails++;
          $display("FAIL b2b_latency: strobe after edge E0+%0d, expected E0+%0d", o.cyc - e0a, 2 + H + CPB * 9 + 1);
        end
      end
      k++;
    end
    obs.delete(); sb.delete();
    // Active rises on the validated start sample edge, E0+3+H.
    checks++;
    if (rise_q.size() != 2) begin
      fails++;
      $display("FAIL b2b_active_count: got %0d active rises, expected 2", rise_q.size());
    end else begin
      checks++;
      if (rise_q[0].cyc != e0a + 3 + H || rise_q[1].cyc != e0b + 3 + H) begin
        fails++;
        $display("FAIL b2b_active_rise: got E0+%0d and E0+%0d, expected E0+%0d for both",
                 rise_q[0].cyc - e0a, rise_q[1].cyc - e0b, 3 + H);
      end
    end
  endtask

  task automatic test_parity;
    rec_t o, e;
    int   e0;
    push_exp(1, 9'h007, 1'b0, 1'b0, 1'b0);
    send_frame(1, 9'h007, 8, 2, 1'b0, 2'b11, 1, e0);
    idle_line(8);
    push_exp(1, 9'h007, 1'b1, 1'b0, 1'b0);
    send_frame(1, 9'h007, 8, 2, 1'b1, 2'b11, 1, e0);
    idle_line(1);
    for (int t = 0; t < LIMIT && obs.size() < sb.size(); t++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (obs.size() != sb.size()) begin
      fails++;
      $display("FAIL parity_count: got %0d strobes, expected %0d", obs.size(), sb.size());
    end
    while (obs.size() > 0 && sb.size() > 0) begin
      o = obs.pop_front(); e = sb.pop_front(); checks++;
      if ({o.dut, o.data, o.pe, o.fe, o.brk, o.act} !== {e.dut, e.data, e.pe, e.fe, e.brk, e.act}) begin
        fails++;
        $display("FAIL parity_word: got dut=%0d data=%h pe=%b fe=%b brk=%b act=%b, expected dut=%0d data=%h pe=%b fe=0 brk=0 act=0",
                 o.dut, o.data, o.pe, o.fe, o.brk, o.act, e.dut, e.data, e.pe);
      end
    end
    obs.delete(); sb.delete();
  endtask

  task automatic test_frame_err;
    rec_t o, e;
    int   e0;
    push_exp(2, 9'h041, 1'b0, 1'b0, 1'b0);
    send_frame(2, 9'h041, 7, 1, 1'b0, 2'b11, 2, e0);
    idle_line(8);
    // First stop high, second stop low.
    push_exp(2, 9'h041, 1'b0, 1'b1, 1'b0);
    send_frame(2, 9'h041, 7, 1, 1'b0, 2'b01, 2, e0);
    idle_line(1);
    for (int t = 0; t < LIMIT && obs.size() < sb.size(); t++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (obs.size() != sb.size()) begin
      fails++;
      $display("FAIL frame_count: got %0d strobes, expected %0d", obs.size(), sb.size());
    end
    while (obs.size() > 0 && sb.size() > 0) begin
      o = obs.pop_front(); e = sb.pop_front(); checks++;
      if ({o.dut, o.data, o.pe, o.fe, o.brk, o.act} !== {e.dut, e.data, e.pe, e.fe, e.brk, e.act}) begin
        fails++;
        $display("FAIL frame_word: got dut=%0d data=%h pe=%b fe=%b brk=%b act=%b, expected dut=%0d data=%h pe=0 fe=%b brk=0 act=0",
                 o.dut, o.data, o.pe, o.fe, o.brk, o.act, e.dut, e.data, e.fe);
      end
    end
    obs.delete(); sb.delete();
  endtask

  task automatic test_glitch;
    rec_t o, e;
    int   e0;
    rise_q.delete();
    // One cycle low on the line gives a one-cycle (H-1) low at the synchroniser output.
    @(negedge clk); rx[0] = 1'b0;
    @(negedge clk); rx[0] = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (obs.size() != 0 || rise_q.size() != 0) begin
      fails++;
      $display("FAIL glitch_reject: got %0d strobes and %0d active rises, expected 0 and 0", obs.size(), rise_q.size());
    end
    obs.delete();
    // The receiver must be back in idle and take the next frame normally.
    push_exp(0, 9'h05A, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 2'b11, 1, e0);
    idle_line(1);
    for (int t = 0; t < LIMIT && obs.size() < sb.size(); t++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (obs.size() != sb.size()) begin
      fails++;
      $display("FAIL glitch_count: got %0d strobes, expected %0d", obs.size(), sb.size());
    end
    while (obs.size() > 0 && sb.size() > 0) begin
      o = obs.pop_front(); e = sb.pop_front(); checks++;
      if ({o.dut, o.data, o.pe, o.fe, o.brk, o.act} !== {e.dut, e.data, e.pe, e.fe, e.brk, e.act}) begin
        fails++;
        $display("FAIL glitch_word: got dut=%0d data=%h pe=%b fe=%b brk=%b act=%b, expected dut=0 data=%h pe=0 fe=0 brk=0 act=0",
                 o.dut, o.data, o.pe, o.fe, o.brk, o.act, e.data);
      end
    end
    obs.delete(); sb.delete();
  endtask

  task automatic test_break;
    rec_t o, e;
    int   e0;
    push_exp(0, 9'h000, 1'b0, 1'b1, 1'b1);
    @(negedge clk); rx[0] = 1'b0;
    repeat (3 * 10 * CPB) @(negedge clk);
    checks++;
    if (obs.size() != 1) begin
      fails++;
      $display("FAIL break_single: got %0d strobes while line held low, expected 1", obs.size());
    end
    rx[0] = 1'b1;
    repeat (10) @(negedge clk);
    push_exp(0, 9'h03C, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1, e0);
    idle_line(1);
    for (int t = 0; t < LIMIT && obs.size() < sb.size(); t++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (obs.size() != sb.size()) begin
      fails++;
      $display("FAIL break_count: got %0d strobes, expected %0d", obs.size(), sb.size());
    end
    while (obs.size() > 0 && sb.size() > 0) begin
      o = obs.pop_front(); e = sb.pop_front(); checks++;
      if ({o.dut, o.data, o.pe, o.fe, o.brk, o.act} !== {e.dut, e.data, e.pe, e.fe, e.brk, e.act}) begin
        fails++;
        $display("FAIL break_word: got dut=%0d data=%h pe=%b fe=%b brk=%b act=%b, expected dut=0 data=%h pe=0 fe=%b brk=%b act=0",
                 o.dut, o.data, o.pe, o.fe, o.brk, o.act, e.data, e.fe, e.brk);
      end
    end
    obs.delete(); sb.delete();
  endtask

  task automatic test_reset_mid;
    rec_t o, e;
    int   e0;
    // Frame 0xF0: start and data bits 0..3 low, bits 4..7 and stop high.
    @(negedge clk); rx[0] = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    rx[0] = 1'b1;
    repeat (H) @(negedge clk);
    checks++;
    if (act[0] !== 1'b1) begin
      fails++;
      $display("FAIL midreset_active_before: got %b, expected 1", act[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({dv[0], pe[0], fe[0], brk[0], act[0]} !== 5'b00000 || byte_o[0] !== 9'h000) begin
      fails++;
      $display("FAIL midreset_outputs: got flags=%b byte=%h, expected flags=00000 byte=000",
               {dv[0], pe[0], fe[0], brk[0], act[0]}, byte_o[0]);
    end
    repeat (4 * CPB + 40) @(negedge clk);
    checks++;
    if (obs.size() != 0) begin
      fails++;
      $display("FAIL midreset_no_strobe: got %0d strobes, expected 0", obs.size());
    end
    obs.delete();
    push_exp(0, 9'h0C3, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h0C3, 8, 0, 1'b0, 2'b11, 1, e0);
    idle_line(1);
    for (int t = 0; t < LIMIT && obs.size() < sb.size(); t++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (obs.size() != sb.size()) begin
      fails++;
      $display("FAIL midreset_count: got %0d strobes, expected %0d", obs.size(), sb.size());
    end
    while (obs.size() > 0 && sb.size() > 0) begin
      o = obs.pop_front(); e = sb.pop_front(); checks++;
      if ({o.dut, o.data, o.pe, o.fe, o.brk, o.act} !== {e.dut, e.data, e.pe, e.fe, e.brk, e.act}) begin
        fails++;
        $display("FAIL midreset_word: got dut=%0d data=%h pe=%b fe=%b brk=%b act=%b, expected dut=0 data=%h pe=0 fe=0 brk=0 act=0",
                 o.dut, o.data, o.pe, o.fe, o.brk, o.act, e.data);
      end
    end
    obs.delete(); sb.delete();
  endtask

  // Test sequence.
  initial begin
    rst = 1'b1;
    rx  = 3'b111;
    test_reset();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_glitch();
    test_break();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
